// File: rtl/radix3_delay_commutator.sv
// radix3_delay_commutator
//   Three-lane complex-sample delay commutator for the radix-3^k FFT pipeline.
//   Each frame is 3 blocks of D samples per lane. The block performs a 3x3 block
//   transpose: output lane q, block p, offset t carries input lane p, block q,
//   offset t. Output block 0 offset 0 appears 2D enabled cycles after input
//   block 0 offset 0, and streaming continues across frames without bubbles.
//
// Ports
//   clk                         rising-edge clock
//   rst                         asynchronous active-high reset
//   En                          sample valid / advance; nothing moves while low
//   sync                        frame realign (qualified by En): current sample is t=0, p=0
//   a_*/b_*/c_* (re, img)       lane 0/1/2 input sample, DATA_W bits per component
//   ao_*/bo_*/co_* (re, img)    lane 0/1/2 output sample (registered)
//   out_valid                   outputs hold a transposed sample this cycle
module radix3_delay_commutator #(
  parameter int DATA_W = 32,
  parameter int D      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic              sync,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_img,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_img,
  input  logic [DATA_W-1:0] c_re,
  input  logic [DATA_W-1:0] c_img,
  output logic [DATA_W-1:0] ao_re,
  output logic [DATA_W-1:0] ao_img,
  output logic [DATA_W-1:0] bo_re,
  output logic [DATA_W-1:0] bo_img,
  output logic [DATA_W-1:0] co_re,
  output logic [DATA_W-1:0] co_img,
  output logic              out_valid
);

  localparam int SW  = 2 * DATA_W;
  localparam int T_W = (D > 1) ? $clog2(D) : 1;
  localparam int F_W = $clog2(2 * D + 1);
  localparam logic [F_W-1:0] FILL_MAX = F_W'(2 * D);

  // re/img travel together as one opaque word per lane
  logic [SW-1:0] lane_in [3];
  assign lane_in[0] = {a_re, a_img};
  assign lane_in[1] = {b_re, b_img};
  assign lane_in[2] = {c_re, c_img};

  logic [T_W-1:0] t_reg, cur_t, t_next;
  logic [1:0]     p_reg, cur_p, p_next, out_p;
  logic           t_wrap;
  logic [F_W-1:0] fill_reg, fill_next;
  logic           fill_done;
  logic           valid_reg;
  logic [SW-1:0]  out_reg  [3];
  logic [SW-1:0]  sel_data [3];

  // lane_tap[k][q]: input lane k delayed by (2+k-q)*D enabled cycles,
  // i.e. the word output lane q needs when the output block index equals k.
  logic [SW-1:0]  lane_tap [3][3];

  always_comb begin
    // sync makes the sample presented this cycle t=0 of block 0
    cur_t  = sync ? '0 : t_reg;
    cur_p  = sync ? 2'd0 : p_reg;
    // The output phase lags by 2D of a 3D frame, so its block index is
    // always (input block + 1) mod 3 with the same offset.
    out_p  = (cur_p == 2'd2) ? 2'd0 : cur_p + 2'd1;
    t_wrap = (cur_t == T_W'(D - 1));
    t_next = t_wrap ? '0 : cur_t + 1'b1;
    p_next = t_wrap ? out_p : cur_p;
    // Fill count of enabled samples since reset/sync, saturating at 2D.
    // A sync in the completing cycle wins and restarts the count.
    fill_done = !sync && (fill_reg == FILL_MAX);
    if (sync)
      fill_next = F_W'(1);
    else if (fill_done)
      fill_next = fill_reg;
    else
      fill_next = fill_reg + 1'b1;
  end

  // Per-lane delay lines: lane k is read at most (2+k)*D samples back.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      localparam int LEN = (2 + gi) * D;
      logic [SW-1:0] hist [LEN];

      always_ff @(posedge clk) begin
        if (En) begin
          hist[0] <= lane_in[gi];
          for (int j = 1; j < LEN; j++)
            hist[j] <= hist[j-1];
        end
      end

      for (gj = 0; gj < 3; gj++) begin : g_tap
        localparam int DL = (2 + gi - gj) * D;
        // Zero delay (lane a block 2 -> lane c block 0) bypasses storage.
        if (DL == 0) begin : g_bypass
          assign lane_tap[gi][gj] = lane_in[gi];
        end else begin : g_delay
          assign lane_tap[gi][gj] = hist[DL-1];
        end
      end
    end
  endgenerate

  always_comb begin
    for (int q = 0; q < 3; q++) begin
      case (out_p)
        2'd0:    sel_data[q] = lane_tap[0][q];
        2'd1:    sel_data[q] = lane_tap[1][q];
        default: sel_data[q] = lane_tap[2][q];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_reg     <= '0;
      p_reg     <= '0;
      fill_reg  <= '0;
      valid_reg <= 1'b0;
      for (int k = 0; k < 3; k++)
        out_reg[k] <= '0;
    end else begin
      valid_reg <= En && fill_done;
      if (En) begin
        t_reg    <= t_next;
        p_reg    <= p_next;
        fill_reg <= fill_next;
        for (int k = 0; k < 3; k++)
          out_reg[k] <= sel_data[k];
      end
    end
  end

  assign ao_re     = out_reg[0][SW-1:DATA_W];
  assign ao_img    = out_reg[0][DATA_W-1:0];
  assign bo_re     = out_reg[1][SW-1:DATA_W];
  assign bo_img    = out_reg[1][DATA_W-1:0];
  assign co_re     = out_reg[2][SW-1:DATA_W];
  assign co_img    = out_reg[2][DATA_W-1:0];
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_radix3_delay_commutator.sv
// Bench for radix3_delay_commutator: three instances (D=1/32b, D=3/32b,
// D=5/16b) share one stimulus stream. A reference model stores every accepted
// input since the last reset/sync, indexed by enabled cycle, and derives each
// expected output from the frame arithmetic Out[q][p][t] = In[p][q][t].
module tb_radix3_delay_commutator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, En, sync;
  logic [31:0] in_re [3];
  logic [31:0] in_im [3];
  logic [31:0] ore [2][3];
  logic [31:0] oim [2][3];
  logic [15:0] ore5 [3];
  logic [15:0] oim5 [3];
  logic        ov [3];

  int          DD [3] = '{1, 3, 5};
  logic [31:0] h_re [3][1024];
  logic [31:0] h_im [3][1024];
  int          cnt, cur;
  logic        last_ok [3];
  logic [31:0] last_re [3][3];
  logic [31:0] last_im [3][3];
  int          n_checks, n_fail;
  logic [31:0] vec_a [3];
  logic [31:0] vec_b [3];
  logic [31:0] vec_c [3];
  logic [31:0] exp_ao [3];
  logic [31:0] exp_bo [3];
  logic [31:0] exp_co [3];

  radix3_delay_commutator #(.DATA_W(32), .D(1)) u_d1 (
    .clk(clk), .rst(rst), .En(En), .sync(sync),
    .a_re(in_re[0]), .a_img(in_im[0]), .b_re(in_re[1]), .b_img(in_im[1]),
    .c_re(in_re[2]), .c_img(in_im[2]),
    .ao_re(ore[0][0]), .ao_img(oim[0][0]), .bo_re(ore[0][1]), .bo_img(oim[0][1]),
    .co_re(ore[0][2]), .co_img(oim[0][2]), .out_valid(ov[0]));

  radix3_delay_commutator #(.DATA_W(32), .D(3)) u_d3 (
    .clk(clk), .rst(rst), .En(En), .sync(sync),
    .a_re(in_re[0]), .a_img(in_im[0]), .b_re(in_re[1]), .b_img(in_im[1]),
    .c_re(in_re[2]), .c_img(in_im[2]),
    .ao_re(ore[1][0]), .ao_img(oim[1][0]), .bo_re(ore[1][1]), .bo_img(oim[1][1]),
    .co_re(ore[1][2]), .co_img(oim[1][2]), .out_valid(ov[1]));

  radix3_delay_commutator #(.DATA_W(16), .D(5)) u_d5 (
    .clk(clk), .rst(rst), .En(En), .sync(sync),
    .a_re(in_re[0][15:0]), .a_img(in_im[0][15:0]), .b_re(in_re[1][15:0]), .b_img(in_im[1][15:0]),
    .c_re(in_re[2][15:0]), .c_img(in_im[2][15:0]),
    .ao_re(ore5[0]), .ao_img(oim5[0]), .bo_re(ore5[1]), .bo_img(oim5[1]),
    .co_re(ore5[2]), .co_img(oim5[2]), .out_valid(ov[2]));

  function automatic logic [31:0] obs_re(input int di, input int q);
    if (di < 2) return ore[di][q];
    return {16'h0, ore5[q]};
  endfunction

  function automatic logic [31:0] obs_im(input int di, input int q);
    if (di < 2) return oim[di][q];
    return {16'h0, oim5[q]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Expected output on lane q of a D=dd instance at enabled cycle n (n >= 2dd)
  task automatic exp_out(input int dd, input int n, input int q,
                         output logic [31:0] er, output logic [31:0] ei);
    int m, f, r, p, t, src;
    m   = n - 2 * dd;
    f   = m / (3 * dd);
    r   = m % (3 * dd);
    p   = r / dd;
    t   = r % dd;
    src = f * 3 * dd + q * dd + t;
    er  = h_re[p][src];
    ei  = h_im[p][src];
  endtask

  task automatic check_step(input logic en_v);
    logic        ev;
    logic [31:0] er, ei;
    for (int di = 0; di < 3; di++) begin
      if (en_v) begin
        ev = (cur >= 2 * DD[di]);
        chk($sformatf("valid_D%0d_n%0d", DD[di], cur), {31'b0, ov[di]}, {31'b0, ev});
        last_ok[di] = ev;
        if (ev) begin
          for (int q = 0; q < 3; q++) begin
            exp_out(DD[di], cur, q, er, ei);
            if (di == 2) begin
              er = er & 32'h0000ffff;
              ei = ei & 32'h0000ffff;
            end
            last_re[di][q] = er;
            last_im[di][q] = ei;
            chk($sformatf("re_D%0d_lane%0d_n%0d", DD[di], q, cur), obs_re(di, q), er);
            chk($sformatf("im_D%0d_lane%0d_n%0d", DD[di], q, cur), obs_im(di, q), ei);
          end
        end
      end else begin
        chk($sformatf("stall_valid_D%0d", DD[di]), {31'b0, ov[di]}, 32'd0);
        if (last_ok[di]) begin
          for (int q = 0; q < 3; q++) begin
            chk($sformatf("hold_re_D%0d_lane%0d", DD[di], q), obs_re(di, q), last_re[di][q]);
            chk($sformatf("hold_im_D%0d_lane%0d", DD[di], q), obs_im(di, q), last_im[di][q]);
          end
        end
      end
    end
  endtask

  task automatic step(input logic en_v, input logic sync_v);
    En   = en_v;
    sync = sync_v;
    @(posedge clk);
    #1;
    if (en_v) begin
      cur = sync_v ? 0 : cnt;
      if (cur < 1024) begin
        for (int k = 0; k < 3; k++) begin
          h_re[k][cur] = in_re[k];
          h_im[k][cur] = in_im[k];
        end
      end
      cnt = cur + 1;
    end
    check_step(en_v);
    $display("step en=%0b sync=%0b n=%0d valid=%0b%0b%0b", en_v, sync_v, cur, ov[0], ov[1], ov[2]);
  endtask

  task automatic model_reset();
    cnt = 0;
    cur = 0;
    for (int di = 0; di < 3; di++) last_ok[di] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    for (int di = 0; di < 3; di++) begin
      chk($sformatf("%s_valid_D%0d", tag, DD[di]), {31'b0, ov[di]}, 32'd0);
      for (int q = 0; q < 3; q++) begin
        chk($sformatf("%s_re_D%0d_lane%0d", tag, DD[di], q), obs_re(di, q), 32'd0);
        chk($sformatf("%s_im_D%0d_lane%0d", tag, DD[di], q), obs_im(di, q), 32'd0);
      end
    end
  endtask

  // Pulse rst between clock edges and check the outputs clear without a clock
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1 check_zero(tag);
    #1 rst = 1'b0;
    model_reset();
    $display("async reset %s", tag);
  endtask

  task automatic rand_in();
    for (int k = 0; k < 3; k++) begin
      in_re[k] = $urandom;
      in_im[k] = $urandom;
    end
  endtask

  task automatic count_in(input int i);
    for (int k = 0; k < 3; k++) begin
      in_re[k] = 32'(k * 1000 + i);
      in_im[k] = 32'(k * 1000 + i + 20000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    En   = 1'b0;
    sync = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_re[k] = '0;
      in_im[k] = '0;
    end
    model_reset();

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

    // D=1 directed vectors (img carries the bitwise complement of re)
    vec_a  = '{32'h3f491a30, 32'h3fcae148, 32'h414c0000};
    vec_b  = '{32'h3f15c290, 32'hc2960000, 32'h42460000};
    vec_c  = '{32'hc14c0000, 32'h414c0000, 32'h415891a3};
    exp_ao = '{32'h3f491a30, 32'h3f15c290, 32'hc14c0000};
    exp_bo = '{32'h3fcae148, 32'hc2960000, 32'h414c0000};
    exp_co = '{32'h414c0000, 32'h42460000, 32'h415891a3};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_re[0] = vec_a[i];
        in_re[1] = vec_b[i];
        in_re[2] = vec_c[i];
      end else begin
        for (int k = 0; k < 3; k++) in_re[k] = $urandom;
      end
      for (int k = 0; k < 3; k++) in_im[k] = ~in_re[k];
      step(1'b1, 1'b0);
      if (i >= 2) begin
        chk($sformatf("vec_ao_re_%0d", i - 2), ore[0][0], exp_ao[i-2]);
        chk($sformatf("vec_bo_re_%0d", i - 2), ore[0][1], exp_bo[i-2]);
        chk($sformatf("vec_co_re_%0d", i - 2), ore[0][2], exp_co[i-2]);
        chk($sformatf("vec_ao_im_%0d", i - 2), oim[0][0], ~exp_ao[i-2]);
        chk($sformatf("vec_bo_im_%0d", i - 2), oim[0][1], ~exp_bo[i-2]);
        chk($sformatf("vec_co_im_%0d", i - 2), oim[0][2], ~exp_co[i-2]);
      end
    end

    // Back-to-back counting frames (4+ frames at D=3, 4 frames at D=5)
    async_reset("midrun_reset1");
    for (int i = 0; i < 60; i++) begin
      count_in(i);
      step(1'b1, 1'b0);
    end

    // Random data with about 30% idle cycles
    for (int i = 0; i < 120; i++) begin
      rand_in();
      step(($urandom_range(0, 9) >= 3) ? 1'b1 : 1'b0, 1'b0);
    end

    // sync at t=2 of block 1 of the D=3 frame
    for (int i = 0; i < 9 && (cnt % 9) != 5; i++) begin
      rand_in();
      step(1'b1, 1'b0);
    end
    rand_in();
    step(1'b1, 1'b1);
    // sync while En=0 is ignored
    rand_in();
    step(1'b0, 1'b1);
    // sync in the cycle where the D=3 fill would complete
    for (int i = 0; i < 10 && cnt != 6; i++) begin
      rand_in();
      step(1'b1, 1'b0);
    end
    rand_in();
    step(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      rand_in();
      step(($urandom_range(0, 9) >= 3) ? 1'b1 : 1'b0, 1'b0);
    end

    // Asynchronous reset mid-frame, then refill
    for (int i = 0; i < 13; i++) begin
      rand_in();
      step(1'b1, 1'b0);
    end
    async_reset("midframe_reset");
    for (int i = 0; i < 30; i++) begin
      rand_in();
      step(1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
